wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port at the writeback end of the pipeline. It shares the port between the in-order pipeline writeback, which is the output of the W-stage pipeline register, and results returned by the long-latency multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained on idle write-port cycles. Starvation of buffered results is bounded by a one-cycle pipeline stall request.

## Interface
Parameters:
- DEPTH, 2: MDU result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive blocked cycles (≥1) before a stall is forced.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pipe_we  in  1  pipeline writeback valid (from W stage).
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline writeback data.
- mdu_valid  in  1  MDU result valid.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  MDU result accepted this cycle when high with mdu_valid.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- wb_stall  out  1  registered; the pipeline write is not committed this cycle, and W/upstream must hold.
- pend_mask  out  32  bit i set iff a FIFO entry targets x_i; feeds the hazard unit.
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: circular buffer, read/write pointers plus count.
  - Enqueue when mdu_valid && mdu_ready.
  - mdu_ready = (count < DEPTH). No enqueue when full, even if a dequeue occurs the same cycle.
- MDU results with mdu_rd == 0 are accepted and discarded; they are never enqueued or written.
- Drain condition: count ≠ 0 && (!pipe_we || pipe_rd == 0 || wb_stall).
- When drain is true, the port carries the FIFO head and the head is dequeued at the edge. Otherwise the port carries the pipe write.
- rf_we is never asserted with rf_waddr == 0. When no write occurs, rf_waddr and rf_wdata are 0.
- Starvation counter: increments each cycle with count ≠ 0 and no drain; cleared on any drain or when empty.
  - When the counter equals STARVE_LIMIT-1 and the FIFO is still blocked, wb_stall is registered high for exactly the next cycle and the counter clears.
  - wb_stall never asserts on two consecutive cycles.
- The hazard unit guarantees no pipe write targets a register set in pend_mask. The arbiter does not check this.
- Outputs mdu_ready, rf_*, pend_mask and fifo_cnt are combinational from registered state and current inputs. wb_stall is a flop.

## Timing
- Reset values:
  - count, pointers, starvation counter and wb_stall are 0.
  - Hence mdu_ready=1, pend_mask=0, fifo_cnt=0, rf_we=0 while pipe_we=0.
- Reset mid-operation: all buffered results are lost. Any stall in flight is dropped.
- Pipe write latency is 0: same cycle, combinational pass-through.
- MDU write latency without bypass: ≥1 cycle after acceptance, i.e. the earliest drain is the cycle after enqueue.
- Worst case an enqueued head waits STARVE_LIMIT+1 cycles: STARVE_LIMIT blocked cycles, then the stall cycle writes it.
- Simultaneous enqueue and dequeue (not full) leaves count unchanged. pend_mask reflects post-edge contents the next cycle.
- Pointer wrap at DEPTH is natural modulo.

## Configuration
- WB_BYPASS_EN defined: when count == 0, no pipe write occupies the port, and mdu_valid && mdu_rd ≠ 0, the MDU result is written to the register file in the same cycle and not enqueued. MDU latency is then 0.
- WB_BYPASS_EN undefined: every MDU result goes through the FIFO.

## Test plan
- Reset behaviour: assert rst low mid-drain with 2 entries -> fifo_cnt=0, mdu_ready=1, wb_stall=0, pend_mask=0 immediately.
- Idle drain: MDU rd=5, data=0x1234 with pipe idle.
  - Without WB_BYPASS_EN: rf_we=1, rf_waddr=5, rf_wdata=0x1234 on the next cycle; pend_mask bit5 high for 1 cycle.
  - With WB_BYPASS_EN: the same write happens in the same cycle.
- Full: 2 MDU results while pipe writes every cycle -> mdu_ready=0 after 2 accepts; a third result is held until a drain frees an entry.
- Starvation: 1 entry, pipe_we=1 with rd≠0 continuously, STARVE_LIMIT=4 -> wb_stall=1 on the 5th cycle after enqueue, FIFO head written that cycle, pipe write committed the following cycle.
- x0 handling: MDU rd=0 -> accepted, fifo_cnt stays 0, no rf_we. pipe rd=0 with 1 entry pending -> the entry drains that cycle.
- Ordering: enqueue rd=3 then rd=7 -> written in order 3 then 7 on consecutive idle cycles.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_port_arbiter                                              |
// | Description : Shares the register-file write port between W-stage          |
// |               writeback and buffered MDU results. Optional build macro:    |
// |               WB_BYPASS_EN (same-cycle MDU write when the port is idle).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     wb_stall,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT - 1);
  localparam logic [AW:0]   c_depth      = (AW+1)'(DEPTH);

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;

  logic w_full;
  logic w_port_free;
  logic w_drain;
  logic w_blocked;
  logic w_bypass;
  logic w_enq;

  assign w_full      = (r_count == c_depth);
  assign mdu_ready   = !w_full;
  // The port is free for the FIFO when the pipe has nothing to commit or is held by a stall.
  assign w_port_free = !pipe_we || (pipe_rd == 5'd0) || r_stall;
  assign w_drain     = (r_count != '0) && w_port_free;
  assign w_blocked   = (r_count != '0) && !w_port_free;

`ifdef WB_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_port_free && mdu_valid && (mdu_rd != 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // Results to x0 are accepted but never stored.
  assign w_enq = mdu_valid && mdu_ready && (mdu_rd != 5'd0) && !w_bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_drain) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= mdu_rd;
      r_data[r_wptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (w_blocked && (r_starve == c_starve_max)) begin
      r_starve <= '0;
      r_stall  <= 1'b1;
    end else begin
      r_stall  <= 1'b0;
      r_starve <= w_blocked ? (r_starve + 1'b1) : '0;
    end
  end

  assign wb_stall = r_stall;
  assign fifo_cnt = r_count;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (w_drain) begin
      rf_we    = 1'b1;
      rf_waddr = r_rd[r_rptr];
      rf_wdata = r_data[r_rptr];
    end else if (w_bypass) begin
      rf_we    = 1'b1;
      rf_waddr = mdu_rd;
      rf_wdata = mdu_data;
    end else if (pipe_we && (pipe_rd != 5'd0) && !r_stall) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pend_mask = 32'd0;
    for (int s = 0; s < DEPTH; s++) begin
      if ({1'b0, AW'(AW'(s) - r_rptr)} < r_count) begin
        pend_mask[r_rd[s]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_port_arbiter                                           |
// | Description : Directed scoreboard bench for wb_port_arbiter.               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [31:0] pend_mask;
  logic [$clog2(DEPTH):0] fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  wb_port_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .mdu_valid (mdu_valid),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_stall  (wb_stall),
    .pend_mask (pend_mask),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_we   = pwe;
    pipe_rd   = prd;
    pipe_data = pd;
    mdu_valid = mv;
    mdu_rd    = mrd;
    mdu_data  = md;
    #1;
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-port monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_write: want x%0d=%h at cycle %0d, none by cycle %0d",
               mon_e.addr, mon_e.data, mon_e.cyc, cyc);
    end
    n_checks++;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h at cycle %0d, want no write",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.addr != rf_waddr || mon_e.data != rf_wdata) begin
          n_fail++;
          $display("FAIL rf_write: got x%0d=%h at cycle %0d, want x%0d=%h at cycle %0d",
                   rf_waddr, rf_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end else if (rf_waddr != 5'd0 || rf_wdata != 32'd0) begin
      n_fail++;
      $display("FAIL idle_port: got addr %0d data %h, want 0/0 (cycle %0d)",
               rf_waddr, rf_wdata, cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("reset_cnt",   32'(fifo_cnt), 32'd0);
    chk("reset_ready", 32'(mdu_ready), 32'd1);
    chk("reset_stall", 32'(wb_stall), 32'd0);
    chk("reset_pend",  pend_mask, 32'd0);
    chk("reset_we",    32'(rf_we), 32'd0);
    rst = 1'b1;
    tick();

    // Idle drain of a single MDU result
    tick(); c = cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    chk("idle_ready", 32'(mdu_ready), 32'd1);
`ifdef WB_BYPASS_EN
    expect_wr(c, 5'd5, 32'h1234);
`else
    expect_wr(c + 1, 5'd5, 32'h1234);
`endif
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_BYPASS_EN
    chk("idle_pend", pend_mask, 32'd0);
    chk("idle_cnt",  32'(fifo_cnt), 32'd0);
`else
    chk("idle_pend", pend_mask, 32'h0000_0020);
    chk("idle_cnt",  32'(fifo_cnt), 32'd1);
`endif
    tick();
    chk("idle_pend_clr", pend_mask, 32'd0);
    chk("idle_cnt_clr",  32'(fifo_cnt), 32'd0);

    // MDU result to x0 is swallowed
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    chk("x0_ready", 32'(mdu_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("x0_cnt",  32'(fifo_cnt), 32'd0);
    chk("x0_pend", pend_mask, 32'd0);

    // Ordering: rd=3 then rd=7
    tick(); c = cyc;
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd3, 32'h33);
    expect_wr(c, 5'd1, 32'hA1);
    tick();
    drive(1'b1, 5'd2, 32'hA2, 1'b1, 5'd7, 32'h77);
    expect_wr(c + 1, 5'd2, 32'hA2);
    chk("ord_cnt1",  32'(fifo_cnt), 32'd1);
    chk("ord_pend1", pend_mask, 32'h0000_0008);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 2, 5'd3, 32'h33);
    chk("ord_cnt2",   32'(fifo_cnt), 32'd2);
    chk("ord_pend2",  pend_mask, 32'h0000_0088);
    chk("ord_ready2", 32'(mdu_ready), 32'd0);
    tick();
    expect_wr(c + 3, 5'd7, 32'h77);
    chk("ord_cnt3",  32'(fifo_cnt), 32'd1);
    chk("ord_pend3", pend_mask, 32'h0000_0080);
    tick();
    chk("ord_cnt4", 32'(fifo_cnt), 32'd0);

    // Full FIFO under continuous pipe writes; third result waits for a free slot
    tick(); c = cyc;
    drive(1'b1, 5'd10, 32'hB0, 1'b1, 5'd4, 32'h44);
    expect_wr(c, 5'd10, 32'hB0);
    tick();
    drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd6, 32'h66);
    expect_wr(c + 1, 5'd11, 32'hB1);
    chk("full_cnt1", 32'(fifo_cnt), 32'd1);
    tick();
    drive(1'b1, 5'd12, 32'hB2, 1'b1, 5'd8, 32'h88);
    expect_wr(c + 2, 5'd12, 32'hB2);
    chk("full_cnt2",  32'(fifo_cnt), 32'd2);
    chk("full_ready", 32'(mdu_ready), 32'd0);
    tick();
    drive(1'b1, 5'd13, 32'hB3, 1'b1, 5'd8, 32'h88);
    expect_wr(c + 3, 5'd13, 32'hB3);
    chk("full_ready3", 32'(mdu_ready), 32'd0);
    tick();
    drive(1'b1, 5'd14, 32'hB4, 1'b1, 5'd8, 32'h88);
    expect_wr(c + 4, 5'd14, 32'hB4);
    chk("full_stall4", 32'(wb_stall), 32'd0);
    tick();
    drive(1'b1, 5'd15, 32'hB5, 1'b1, 5'd8, 32'h88);
    expect_wr(c + 5, 5'd4, 32'h44);
    chk("full_stall5", 32'(wb_stall), 32'd1);
    chk("full_ready5", 32'(mdu_ready), 32'd0);
    tick();
    drive(1'b1, 5'd15, 32'hB5, 1'b1, 5'd8, 32'h88);
    expect_wr(c + 6, 5'd15, 32'hB5);
    chk("full_stall6", 32'(wb_stall), 32'd0);
    chk("full_ready6", 32'(mdu_ready), 32'd1);
    chk("full_pend6",  pend_mask, 32'h0000_0040);
    tick();
    drive(1'b1, 5'd16, 32'hB6, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 7, 5'd16, 32'hB6);
    chk("full_cnt7",  32'(fifo_cnt), 32'd2);
    chk("full_pend7", pend_mask, 32'h0000_0140);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 8, 5'd6, 32'h66);
    tick();
    expect_wr(c + 9, 5'd8, 32'h88);
    chk("full_cnt9", 32'(fifo_cnt), 32'd1);
    tick();
    chk("full_cnt10", 32'(fifo_cnt), 32'd0);

    // Starvation: one entry blocked by a busy pipe
    tick(); c = cyc;
    drive(1'b1, 5'd9, 32'hC0, 1'b1, 5'd20, 32'h2020);
    expect_wr(c, 5'd9, 32'hC0);
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      tick();
      drive(1'b1, 5'd9, 32'hC0 + 32'(k), 1'b0, 5'd0, 32'd0);
      expect_wr(c + k, 5'd9, 32'hC0 + 32'(k));
      chk("starve_nostall", 32'(wb_stall), 32'd0);
    end
    tick();
    drive(1'b1, 5'd9, 32'hC5, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 5, 5'd20, 32'h2020);
    chk("starve_stall", 32'(wb_stall), 32'd1);
    chk("starve_pend",  pend_mask, 32'h0010_0000);
    tick();
    drive(1'b1, 5'd9, 32'hC5, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 6, 5'd9, 32'hC5);
    chk("starve_release", 32'(wb_stall), 32'd0);
    chk("starve_cnt",     32'(fifo_cnt), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Pipe write to x0 frees the port for the FIFO head
    tick(); c = cyc;
    drive(1'b1, 5'd1, 32'hD0, 1'b1, 5'd12, 32'hCC);
    expect_wr(c, 5'd1, 32'hD0);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    expect_wr(c + 1, 5'd12, 32'hCC);
    chk("pipex0_cnt", 32'(fifo_cnt), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("pipex0_cnt2", 32'(fifo_cnt), 32'd0);

    // Reset mid-drain with two entries buffered
    tick(); c = cyc;
    drive(1'b1, 5'd1, 32'hE0, 1'b1, 5'd17, 32'h1717);
    expect_wr(c, 5'd1, 32'hE0);
    tick();
    drive(1'b1, 5'd2, 32'hE1, 1'b1, 5'd18, 32'h1818);
    expect_wr(c + 1, 5'd2, 32'hE1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_pre_cnt", 32'(fifo_cnt), 32'd2);
    rst = 1'b0;
    #1;
    chk("rst_mid_cnt",   32'(fifo_cnt), 32'd0);
    chk("rst_mid_ready", 32'(mdu_ready), 32'd1);
    chk("rst_mid_stall", 32'(wb_stall), 32'd0);
    chk("rst_mid_pend",  pend_mask, 32'd0);
    chk("rst_mid_we",    32'(rf_we), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_post_cnt", 32'(fifo_cnt), 32'd0);

    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
